dot_scan_ctrl: RTL
==================

# dot_scan_ctrl

Row-scan scheduler and framebuffer for the 16x8 LED dot matrix of the bomb board. Owns an 8-row x 16-column pixel store. Sequences active-low row strobes with an anti-ghosting blank interval, and arbitrates pixel writes from the game logic against a multi-cycle clear-all command. Replaces the ad-hoc row-scan and keypad-driven `pos` updates in the top level; `dotR`/`dotC` go straight to pins.

## Interface
- `SCAN_DIV`, 2500 — clock cycles per row slot; must exceed `BLANK_CYC`.
- `BLANK_CYC`, 16 — leading cycles of each row slot with all rows off.
- `BLINK_DIV`, 12500000 — cycles per cursor blink half-period; used only with the macro.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  pixel write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready` at a rising edge.
- `wr_row`  in  3  target row, 0..7.
- `wr_col`  in  4  target column, 0..15.
- `wr_op`  in  2  operation: 00 = set, 01 = clear, 10 = toggle, 11 = no-op (still accepted).
- `clr_all`  in  1  single-cycle pulse that starts a framebuffer wipe.
- `clr_busy`  out  1  high while the wipe runs.
- `cursor_row`  in  3  cursor row (blink overlay).
- `cursor_col`  in  4  cursor column.
- `frame_start`  out  1  one-cycle pulse at the start of the row-0 drive phase.
- `dotR`  out  8  row strobes, active low; row r drives bit 7−r low.
- `dotC`  out  16  column data, active high; bit c = pixel (row, c).

## Operation
- Scan counter `cnt` runs 0..`SCAN_DIV`−1. At `SCAN_DIV`−1 it wraps to 0 and the row advances: 7 wraps to 0.
- Each row slot has two FSM states:
  - BLANK (`cnt < BLANK_CYC`): `dotR` = 8'hFF, `dotC` = 0.
  - DRIVE: `dotR` has bit 7−row low, `dotC` = fb[row] (plus overlay).
- `dotR` and `dotC` are registered.
- Write path: `wr_ready` = !`clr_busy` && !`clr_all` (combinational). An accepted write updates fb[wr_row][wr_col] at that edge.
- Clear-all:
  - `clr_all` sampled high starts the wipe: rows 0..7 are zeroed, one row per cycle.
  - `clr_busy` is high for exactly 8 cycles, starting the cycle after the pulse.
  - `clr_all` while `clr_busy` is high is ignored.
  - `clr_all` and `wr_valid` in the same cycle: clear wins and the write is not accepted (`wr_ready` low).
- Scanning continues during a wipe; rows show cleared or uncleared content as they are reached.

## Timing
- Reset values: `dotR` = 8'hFF, `dotC` = 0, `wr_ready` = 1 (when `clr_all` is low), `clr_busy` = 0, `frame_start` = 0, fb all zero, row = 0, `cnt` = 0, state BLANK.
- After reset release:
  - First DRIVE of row 0 begins at cycle `BLANK_CYC`.
  - `frame_start` pulses in that same cycle, then every 8×`SCAN_DIV` cycles.
- Write latency: a write accepted at edge N to the currently driven row appears on `dotC` at edge N+1.
- Reset asserted mid-wipe or mid-scan: all state returns to reset values immediately; the wipe is abandoned.

## Configuration
- `CURSOR_BLINK_EN` defined:
  - A blink counter toggles a phase bit every `BLINK_DIV` cycles; phase resets to 0.
  - In DRIVE, when phase = 1, the `dotC` bit at (`cursor_row`, `cursor_col`) is inverted relative to fb.
  - fb itself is never modified by the overlay.
- Undefined: no blink counter; cursor ports are present but ignored; `dotC` = fb[row] exactly.

## Structure
- Shared package `dot_pkg`:
  - `DOT_ROWS` = 8, `DOT_COLS` = 16.
  - Write-op encodings `OP_SET`, `OP_CLR`, `OP_TGL`, `OP_NOP`.
  - Scan FSM state type (BLANK, DRIVE).
- One sub-module, `dot_fb`:
  - 8×16 register array.
  - Single write port with set/clear/toggle.
  - Sequential wipe engine producing `clr_busy`.
  - Combinational row read port.
- Scan FSM, counters and output registers live in `dot_scan_ctrl`.

## Test plan
- Reset and idle scan (SCAN_DIV = 20, BLANK_CYC = 4) -> `dotR` 8'hFF for 4 cycles, then 8'b01111111 for 16 cycles, then 8'hFF, then 8'b10111111; `frame_start` at cycles 4 and 164; `dotC` = 0 throughout.
- Set (row 0, col 5), then toggle the same pixel twice during the row-0 drive -> `dotC` = 16'h0020 the cycle after the set, returns to 16'h0020 after both toggles; other rows still 0.
- Fill all pixels via writes, then pulse `clr_all` -> `clr_busy` high for 8 cycles, `wr_ready` low during the pulse cycle and while busy; next full frame shows `dotC` = 0 in every row.
- `clr_all` and `wr_valid` (set row 2, col 0) in the same cycle -> write dropped; row 2 reads 0 after the wipe.
- Reset asserted at wipe cycle 3 -> outputs return to reset values asynchronously; `clr_busy` = 0; fb all zero.
- With `CURSOR_BLINK_EN` (BLINK_DIV = 50), cursor at (7, 15), fb empty -> row 7 `dotC` alternates 16'h0000 / 16'h8000 every 50 cycles; without the macro it stays 16'h0000.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared types and constants for the LED dot-matrix scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dot_pkg;

  localparam int DOT_ROWS = 8;
  localparam int DOT_COLS = 16;

  // Pixel write operations; OP_NOP is still a handshake, it just changes nothing.
  typedef enum logic [1:0] {
    OP_SET = 2'b00,
    OP_CLR = 2'b01,
    OP_TGL = 2'b10,
    OP_NOP = 2'b11
  } wr_op_e;

  // Each row slot starts blanked (anti-ghosting), then drives the row.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Active-low strobe: row r pulls bit 7-r low, all other rows stay off.
  function automatic logic [7:0] row_strobe(input logic [2:0] row);
    row_strobe = ~(8'h80 >> row);
  endfunction

endpackage

// File: rtl/dot_fb.sv
// 8x16 pixel store with one set/clear/toggle write port and a row-per-cycle wipe engine.
// Latency: an accepted write or wipe step lands at that edge; the row read port is combinational.
// Backpressure: wr_ready_o is low while a wipe runs and in the cycle a wipe is requested.
module dot_fb
  import dot_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [2:0]          wr_row_i,
  input  logic [3:0]          wr_col_i,
  input  logic [1:0]          wr_op_i,
  input  logic                clr_all_i,
  output logic                clr_busy_o,
  input  logic [2:0]          rd_row_i,
  output logic [DOT_COLS-1:0] rd_dat_o
);

  logic [DOT_COLS-1:0] fb_q [DOT_ROWS];
  logic                busy_q, busy_d;
  logic [2:0]          wipe_row_q, wipe_row_d;
  logic                fb_we;
  logic [2:0]          fb_idx;
  logic [DOT_COLS-1:0] fb_wdat;
  logic [DOT_COLS-1:0] wr_mask;

  // A clear request takes priority over a simultaneous write, so the write is refused.
  assign wr_ready_o = !busy_q && !clr_all_i;
  assign clr_busy_o = busy_q;
  assign rd_dat_o   = fb_q[rd_row_i];
  assign wr_mask    = DOT_COLS'(1) << wr_col_i;

  // Pick the single row update for this cycle: wipe step, wipe start, or pixel write.
  always_comb begin
    busy_d     = busy_q;
    wipe_row_d = wipe_row_q;
    fb_we      = 1'b0;
    fb_idx     = wr_row_i;
    fb_wdat    = fb_q[wr_row_i];
    if (busy_q) begin
      fb_we      = 1'b1;
      fb_idx     = wipe_row_q;
      fb_wdat    = '0;
      wipe_row_d = wipe_row_q + 3'd1;
      if (wipe_row_q == 3'd7) busy_d = 1'b0;
    end else if (clr_all_i) begin
      busy_d     = 1'b1;
      wipe_row_d = 3'd0;
    end else if (wr_valid_i) begin
      fb_we = 1'b1;
      case (wr_op_i)
        OP_SET:  fb_wdat = fb_q[wr_row_i] | wr_mask;
        OP_CLR:  fb_wdat = fb_q[wr_row_i] & ~wr_mask;
        OP_TGL:  fb_wdat = fb_q[wr_row_i] ^ wr_mask;
        default: fb_we   = 1'b0;
      endcase
    end
  end

  // Pixel array and wipe sequencer state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < DOT_ROWS; r++) fb_q[r] <= '0;
      busy_q     <= 1'b0;
      wipe_row_q <= 3'd0;
    end else begin
      if (fb_we) fb_q[fb_idx] <= fb_wdat;
      busy_q     <= busy_d;
      wipe_row_q <= wipe_row_d;
    end
  end

endmodule

// File: rtl/dot_scan_ctrl.sv
// Row-scan scheduler for the 16x8 LED matrix: blank/drive per row slot, registered pin outputs.
// Latency: dotR/dotC registered; a write to the driven row shows on dotC one edge after acceptance.
// Backpressure: wr_ready low during clr_all and the 8-cycle wipe. Optional CURSOR_BLINK_EN adds a blinking cursor.
module dot_scan_ctrl
  import dot_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 2500,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [2:0]          wr_row,
  input  logic [3:0]          wr_col,
  input  logic [1:0]          wr_op,
  input  logic                clr_all,
  output logic                clr_busy,
  input  logic [2:0]          cursor_row,
  input  logic [3:0]          cursor_col,
  output logic                frame_start,
  output logic [7:0]          dotR,
  output logic [DOT_COLS-1:0] dotC
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          row_q, row_d;
  scan_state_e         state_q, state_d;
  logic [7:0]          dotR_q, dotR_d;
  logic [DOT_COLS-1:0] dotC_q, dotC_d;
  logic                frame_start_q, frame_start_d;
  logic [DOT_COLS-1:0] rd_dat;
  logic [DOT_COLS-1:0] overlay;

  dot_fb u_fb (
    .clk_i      (clock),
    .rst_ni     (reset),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .wr_row_i   (wr_row),
    .wr_col_i   (wr_col),
    .wr_op_i    (wr_op),
    .clr_all_i  (clr_all),
    .clr_busy_o (clr_busy),
    .rd_row_i   (row_d),
    .rd_dat_o   (rd_dat)
  );

`ifdef CURSOR_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  // Free-running half-period counter; the phase flips each time it wraps.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLK_W'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = !phase_q;
    end
  end

  // Blink phase register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign overlay = (phase_q && (row_d == cursor_row)) ? (DOT_COLS'(1) << cursor_col) : '0;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_row, cursor_col, BLINK_DIV[0]};
  assign overlay       = '0;
`endif

  // Advance the slot counter and row, derive the blank/drive state and next pin values.
  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    row_d         = row_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      row_d = row_q + 3'd1;
    end
    state_d       = (cnt_d < BLANK_END) ? BLANK : DRIVE;
    dotR_d        = 8'hFF;
    dotC_d        = '0;
    frame_start_d = 1'b0;
    if (state_d == DRIVE) begin
      dotR_d        = row_strobe(row_d);
      dotC_d        = rd_dat ^ overlay;
      frame_start_d = (state_q == BLANK) && (row_d == 3'd0);
    end
  end

  // Scan state and registered pin drivers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      row_q         <= 3'd0;
      state_q       <= BLANK;
      dotR_q        <= 8'hFF;
      dotC_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      state_q       <= state_d;
      dotR_q        <= dotR_d;
      dotC_q        <= dotC_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dotR        = dotR_q;
  assign dotC        = dotC_q;
  assign frame_start = frame_start_q;

endmodule
